// File: rtl/fc_pkg.sv
// Shared types and constants for the fully connected MAC stage.
package fc_pkg;

    localparam int N_IN    = 8;
    localparam int DATA_W  = 8;
    localparam int BIAS_W  = 16;
    localparam int ACC_W   = 20;
    localparam int PROD_W  = 2 * DATA_W;
    localparam int PHASE_W = 4;

    localparam logic [PHASE_W-1:0] FC_BIAS_ADDR = 4'd8;
    localparam logic [PHASE_W-1:0] LAST_PHASE   = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fc_state_e;

endpackage

// File: rtl/fc_mac_unit.sv
// Signed 8x8 multiply feeding a clearable accumulator, plus a bias-add path.
module fc_mac_unit
    import fc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     add_prod,
    input  logic                     add_bias,
    input  logic signed [DATA_W-1:0] feat,
    input  logic signed [DATA_W-1:0] weight,
    input  logic signed [BIAS_W-1:0] bias,
    output logic signed [ACC_W-1:0]  acc_plus_bias
);

    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;

    assign prod          = feat * weight;
    assign prod_ext      = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_ext      = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
    assign acc_plus_bias = acc_q + bias_ext;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (add_prod) begin
            acc_d = acc_q + prod_ext;
        end else if (add_bias) begin
            acc_d = acc_plus_bias;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fc_mac_engine.sv
// FC layer compute stage: walks weight ROM addresses 0..8, accumulates
// feature*weight products, adds the bias and presents one result with done.
module fc_mac_engine
    import fc_pkg::*;
#(
    parameter int RELU = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [N_IN*DATA_W-1:0]      feat_in,
    output logic [PHASE_W-1:0]          rom_addr,
    input  logic signed [DATA_W-1:0]    rom_weight,
    input  logic signed [BIAS_W-1:0]    rom_bias,
    output logic                        busy,
    output logic                        done,
    output logic signed [ACC_W-1:0]     result_out
);

    fc_state_e                 state_q, state_d;
    logic [PHASE_W-1:0]        phase_q, phase_d;
    logic [PHASE_W-1:0]        rom_addr_q, rom_addr_d;
    logic                      done_q, done_d;
    logic signed [ACC_W-1:0]   result_q, result_d;
    logic signed [DATA_W-1:0]  feat_q [N_IN];
    logic signed [DATA_W-1:0]  feat_d [N_IN];

    logic                      mac_clr;
    logic                      mac_add_prod;
    logic                      mac_add_bias;
    logic signed [DATA_W-1:0]  feat_sel;
    logic signed [ACC_W-1:0]   acc_plus_bias;

    // Phase p multiplies the weight returned for address p-1.
    assign feat_sel = feat_q[3'(phase_q - 4'd1)];

    fc_mac_unit u_mac (
        .clk           (clk),
        .rst           (rst),
        .clr           (mac_clr),
        .add_prod      (mac_add_prod),
        .add_bias      (mac_add_bias),
        .feat          (feat_sel),
        .weight        (rom_weight),
        .bias          (rom_bias),
        .acc_plus_bias (acc_plus_bias)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        rom_addr_d   = rom_addr_q;
        done_d       = 1'b0;
        result_d     = result_q;
        feat_d       = feat_q;
        mac_clr      = 1'b0;
        mac_add_prod = 1'b0;
        mac_add_bias = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < N_IN; i++) begin
                        feat_d[i] = feat_in[i*DATA_W +: DATA_W];
                    end
                    mac_clr    = 1'b1;
                    phase_d    = '0;
                    rom_addr_d = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (phase_q != 4'd0 && phase_q <= FC_BIAS_ADDR) begin
                    mac_add_prod = 1'b1;
                end
                if (phase_q == LAST_PHASE) begin
                    mac_add_bias = 1'b1;
                    if (RELU != 0 && acc_plus_bias < 0) begin
                        result_d = '0;
                    end else begin
                        result_d = acc_plus_bias;
                    end
                    done_d     = 1'b1;
                    phase_d    = '0;
                    rom_addr_d = '0;
                    state_d    = DONE;
                end else begin
                    phase_d    = phase_q + 4'd1;
                    rom_addr_d = (phase_q < FC_BIAS_ADDR) ? phase_q + 4'd1 : FC_BIAS_ADDR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            rom_addr_q <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            for (int i = 0; i < N_IN; i++) begin
                feat_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rom_addr_q <= rom_addr_d;
            done_q     <= done_d;
            result_q   <= result_d;
            feat_q     <= feat_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign result_out = result_q;

endmodule

// File: tb/tb_fc_mac_engine.sv
// Directed bench for fc_mac_engine with a behavioural weight ROM; checks
// both RELU=0 and RELU=1 instances driven by identical stimulus.
module tb_fc_mac_engine;
    import fc_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic [N_IN*DATA_W-1:0]     feat_in;
    logic [PHASE_W-1:0]         rom_addr0, rom_addr1;
    logic signed [DATA_W-1:0]   rom_weight;
    logic signed [BIAS_W-1:0]   rom_bias;
    logic                       busy0, busy1, done0, done1;
    logic signed [ACC_W-1:0]    result0, result1;

    logic signed [DATA_W-1:0]   w_tab [9];
    int                         n_checks = 0;
    int                         n_fail = 0;
    int                         done_cnt = 0;
    int                         done_ref;

    always #5 clk = ~clk;

    fc_mac_engine #(.RELU(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .feat_in(feat_in),
        .rom_addr(rom_addr0), .rom_weight(rom_weight), .rom_bias(rom_bias),
        .busy(busy0), .done(done0), .result_out(result0)
    );

    fc_mac_engine #(.RELU(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .feat_in(feat_in),
        .rom_addr(rom_addr1), .rom_weight(rom_weight), .rom_bias(rom_bias),
        .busy(busy1), .done(done1), .result_out(result1)
    );

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) begin
        if (rom_addr0 <= 4'd8) rom_weight <= w_tab[rom_addr0];
        else                   rom_weight <= '0;
    end

    always @(negedge clk) begin
        if (done0) done_cnt = done_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_w_all(input int v);
        for (int i = 0; i < 8; i++) w_tab[i] = DATA_W'(v);
        w_tab[8] = '0;
    endtask

    task automatic set_w_ramp();
        for (int i = 0; i < 8; i++) w_tab[i] = DATA_W'(i + 1);
        w_tab[8] = '0;
    endtask

    task automatic set_feat_ramp();
        for (int i = 0; i < 8; i++) feat_in[i*8 +: 8] = 8'(i + 1);
    endtask

    task automatic set_feat_all(input int v);
        for (int i = 0; i < 8; i++) feat_in[i*8 +: 8] = 8'(v);
    endtask

    // Starts at the current cycle (T0) and ends in T12.
    task automatic run_op(input string tag, input int exp0, input int exp1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk({tag, "_addr"}, int'(rom_addr0), (k <= 9) ? k - 1 : 8);
            chk({tag, "_busy"}, int'(busy0), 1);
            chk({tag, "_nodone"}, int'(done0), 0);
            step();
        end
        chk({tag, "_done_t11"}, int'(done0), 1);
        chk({tag, "_busy_t11"}, int'(busy0), 1);
        chk({tag, "_res0"}, int'(result0), exp0);
        chk({tag, "_res1"}, int'(result1), exp1);
        step();
        chk({tag, "_done_t12"}, int'(done0), 0);
        chk({tag, "_busy_t12"}, int'(busy0), 0);
        chk({tag, "_hold0"}, int'(result0), exp0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        feat_in = '0;
        rom_bias = '0;
        set_w_all(1);
        repeat (3) step();
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_addr", int'(rom_addr0), 0);
        chk("rst_res", int'(result0), 0);
        rst = 1'b0;
        step();

        set_feat_ramp();
        run_op("default", 36, 36);

        set_w_ramp();
        run_op("ramp_w", 204, 204);

        set_w_all(-128);
        rom_bias = 16'sd32767;
        set_feat_all(-128);
        run_op("extreme", 163839, 163839);

        set_w_all(1);
        rom_bias = -16'sd5;
        run_op("relu", -1029, 0);

        // Start pulses while busy at T5 and T11 must be ignored.
        rom_bias = '0;
        set_feat_ramp();
        done_ref = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1;
        set_feat_all(5);
        step();
        start = 1'b0;
        repeat (5) step();
        start = 1'b1;
        set_feat_all(7);
        chk("busy_start_done", int'(done0), 1);
        chk("busy_start_res", int'(result0), 36);
        step();
        start = 1'b0;
        chk("busy_start_idle", int'(busy0), 0);
        repeat (13) step();
        chk("busy_start_idle2", int'(busy0), 0);
        chk("busy_start_ndone", done_cnt - done_ref, 1);

        // Reset asserted at T6 aborts the operation.
        set_feat_ramp();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", int'(busy0), 0);
        chk("abort_addr", int'(rom_addr0), 0);
        chk("abort_res0", int'(result0), 0);
        chk("abort_res1", int'(result1), 0);
        chk("abort_done", int'(done0), 0);
        done_ref = done_cnt;
        repeat (14) step();
        chk("abort_nodone", done_cnt - done_ref, 0);
        chk("abort_idle", int'(busy0), 0);
        set_w_ramp();
        run_op("after_abort", 204, 204);

        // Back-to-back: second start lands at T12.
        set_w_all(1);
        set_feat_ramp();
        run_op("b2b_a", 36, 36);
        set_feat_all(2);
        run_op("b2b_b", 16, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
